// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents:
//   state_t    - scan FSM phase (BLANK: all anodes off, ON: one digit lit)
//   SEG_BLANK  - segment pattern with every segment dark
//   SEG_DIGIT  - segment patterns for BCD 0..9, bit0 = a ... bit6 = g
//   clog2w     - ceil(log2(n)) with a floor of 1, used for counter/index widths
package seg_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Packed so that SEG_DIGIT[n] is the pattern for digit n.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the system-side value registers and the scan controller/pins.
// Signals:
//   en, load, bcd_in, dp_in           - driven by the system side (master)
//   load_ack                          - load acknowledge pulse back to master
//   seg_out, dp_out, an_n             - display pin drives
//   digit_idx, frame_done             - scan position / frame boundary status
interface seg_scan_ctrl_if
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) ();

    localparam int unsigned IW = clog2w(DIGITS);

    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  load_ack;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic [DIGITS-1:0]     an_n;
    logic [IW-1:0]         digit_idx;
    logic                  frame_done;

    modport master (
        output en, load, bcd_in, dp_in,
        input  load_ack, seg_out, dp_out, an_n, digit_idx, frame_done
    );

    modport slave (
        input  en, load, bcd_in, dp_in,
        output load_ack, seg_out, dp_out, an_n, digit_idx, frame_done
    );

endinterface

// File: rtl/seg_scan_ctrl_dec.sv
// BCD to seven-segment decoder, purely combinational.
// Ports:
//   bcd [3:0] - BCD digit in
//   seg [6:0] - active-high segments, bit0 = a ... bit6 = g; codes above 9 give all-dark
module sevenSegment
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit seven-segment
// display. One shared decoder, BLANK gap between digits, frame-atomic updates.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of seg_scan_ctrl_if (enable, load handshake, pin drives,
//            scan position and frame_done pulse); all outputs registered
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned BLANK_CYC   = 16,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned IW   = clog2w(DIGITS);
    localparam int unsigned PMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
    localparam int unsigned CW   = clog2w(PMAX);

    localparam logic [CW-1:0] ON_LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] stage_q, stage_d;
    logic [DIGITS-1:0]   stage_dp_q, stage_dp_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                pend_q, pend_d;
    logic                ack_q, ack_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q, fd_d;

    logic [3:0]          digit_v [DIGITS];
    logic [DIGITS-1:0]   lead_blank;
    logic                lz_run;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_on;
    logic                frame_end;

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_v[i] = disp_q[4*i +: 4];
        end
    end

    // Leading-blank run from the top digit down. Invalid (>9) digits are dark
    // anyway, so they extend the run just like zeros do. Digit 0 is never
    // part of the run.
    always_comb begin
        lead_blank = '0;
        lz_run     = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            lz_run        = lz_run & ((digit_v[i] == 4'd0) | (digit_v[i] > 4'd9));
            lead_blank[i] = lz_run;
        end
    end

    sevenSegment u_dec (
        .bcd (digit_v[idx_q]),
        .seg (dec_seg)
    );

    always_comb begin
        seg_on = dec_seg;
        if ((digit_v[idx_q] > 4'd9) || ((LZ_SUPPRESS != 0) && lead_blank[idx_q])) begin
            seg_on = SEG_BLANK;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        stage_dp_d = stage_dp_q;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;
        ack_d      = bus.load;
        seg_d      = seg_q;
        dp_d       = dp_q;
        an_d       = an_q;
        fd_d       = 1'b0;
        frame_end  = 1'b0;

        if (!bus.en) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = '0;
            an_d    = '1;
            seg_d   = SEG_BLANK;
            dp_d    = 1'b0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d     = ON;
                        cnt_d       = '0;
                        an_d        = '1;
                        an_d[idx_q] = 1'b0;
                        seg_d       = seg_on;
                        dp_d        = disp_dp_q[idx_q];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        an_d    = '1;
                        seg_d   = SEG_BLANK;
                        dp_d    = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            fd_d      = 1'b1;
                            frame_end = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end

        if (bus.load) begin
            stage_d    = bus.bcd_in;
            stage_dp_d = bus.dp_in;
            pend_d     = 1'b1;
        end

        // A load landing on the frame boundary bypasses staging so it is not
        // left pending for a whole extra frame.
        if (frame_end) begin
            if (bus.load) begin
                disp_d    = bus.bcd_in;
                disp_dp_d = bus.dp_in;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                disp_d    = stage_q;
                disp_dp_d = stage_dp_q;
                pend_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            stage_dp_q <= '0;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b0;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stage_q    <= stage_d;
            stage_dp_q <= stage_dp_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.load_ack   = ack_q;
    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.an_n       = an_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4, PRESCALE=4, BLANK_CYC=2).
// A second instance with leading-zero suppression off shares all inputs.
// Edge k = k-th rising edge after reset release; outputs sampled on the
// falling edge that follows it.
module tb_seg_scan_ctrl;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int edge_n;

    seg_scan_ctrl_if #(.DIGITS(4)) bus0 ();
    seg_scan_ctrl_if #(.DIGITS(4)) bus1 ();

    assign bus1.en     = bus0.en;
    assign bus1.load   = bus0.load;
    assign bus1.bcd_in = bus0.bcd_in;
    assign bus1.dp_in  = bus0.dp_in;

    seg_scan_ctrl #(
        .DIGITS      (4),
        .PRESCALE    (4),
        .BLANK_CYC   (2),
        .LZ_SUPPRESS (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    seg_scan_ctrl #(
        .DIGITS      (4),
        .PRESCALE    (4),
        .BLANK_CYC   (2),
        .LZ_SUPPRESS (0)
    ) dut_nolz (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv_to(input int k);
        while (edge_n < k) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        edge_n      = 0;
        rst_n       = 1'b0;
        bus0.en     = 1'b0;
        bus0.load   = 1'b0;
        bus0.bcd_in = '0;
        bus0.dp_in  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_an",   32'(bus0.an_n), 32'hF);
        chk("rst_seg",  32'(bus0.seg_out), 32'h00);
        chk("rst_dp",   32'(bus0.dp_out), 32'h0);
        chk("rst_ack",  32'(bus0.load_ack), 32'h0);
        chk("rst_fd",   32'(bus0.frame_done), 32'h0);
        chk("rst_idx",  32'(bus0.digit_idx), 32'h0);

        rst_n   = 1'b1;
        bus0.en = 1'b1;
        edge_n  = 0;

        // Start-up timing with all-zero display
        adv_to(1);  chk("st_blank_an", 32'(bus0.an_n), 32'hF);
        adv_to(2);  chk("st_d0_an", 32'(bus0.an_n), 32'hE);
                    chk("st_d0_seg", 32'(bus0.seg_out), 32'h3F);
                    chk("st_d0_seg_nolz", 32'(bus1.seg_out), 32'h3F);
                    chk("st_d0_idx", 32'(bus0.digit_idx), 32'h0);
        adv_to(5);  chk("st_d0_an_end", 32'(bus0.an_n), 32'hE);
        adv_to(6);  chk("st_gap_an", 32'(bus0.an_n), 32'hF);
                    chk("st_gap_idx", 32'(bus0.digit_idx), 32'h1);
                    chk("st_gap_seg", 32'(bus0.seg_out), 32'h00);
        adv_to(8);  chk("st_d1_an", 32'(bus0.an_n), 32'hD);
                    chk("st_d1_seg_lz", 32'(bus0.seg_out), 32'h00);
                    chk("st_d1_seg_nolz", 32'(bus1.seg_out), 32'h3F);
        adv_to(23); chk("fd_early", 32'(bus0.frame_done), 32'h0);
        adv_to(24); chk("fd_pulse", 32'(bus0.frame_done), 32'h1);
                    chk("fd_idx", 32'(bus0.digit_idx), 32'h0);
        adv_to(25); chk("fd_clear", 32'(bus0.frame_done), 32'h0);

        // Load mid-frame: ack next cycle, display waits for frame boundary
        adv_to(27); bus0.load = 1'b1; bus0.bcd_in = 16'h1234;
        adv_to(28); chk("ld_ack", 32'(bus0.load_ack), 32'h1);
                    bus0.load = 1'b0;
        adv_to(29); chk("ld_ack_clr", 32'(bus0.load_ack), 32'h0);
        adv_to(32); chk("ld_old_d1", 32'(bus1.seg_out), 32'h3F);
        adv_to(48); chk("ld_fd", 32'(bus0.frame_done), 32'h1);
        adv_to(50); chk("ld_d0", 32'(bus0.seg_out), 32'h66);
                    chk("ld_d0_an", 32'(bus0.an_n), 32'hE);
        adv_to(56); chk("ld_d1", 32'(bus0.seg_out), 32'h4F);
        adv_to(62); chk("ld_d2", 32'(bus0.seg_out), 32'h5B);
                    chk("ld_d2_an", 32'(bus0.an_n), 32'hB);
        adv_to(68); chk("ld_d3", 32'(bus0.seg_out), 32'h06);
                    chk("ld_d3_an", 32'(bus0.an_n), 32'h7);

        // Leading-zero suppression
        adv_to(70); bus0.load = 1'b1; bus0.bcd_in = 16'h0070;
        adv_to(71); chk("lz_ack", 32'(bus0.load_ack), 32'h1);
                    bus0.load = 1'b0;
        adv_to(74); chk("lz_d0", 32'(bus0.seg_out), 32'h3F);
                    chk("lz_d0_nolz", 32'(bus1.seg_out), 32'h3F);
        adv_to(80); chk("lz_d1", 32'(bus0.seg_out), 32'h07);
                    chk("lz_d1_nolz", 32'(bus1.seg_out), 32'h07);
        adv_to(86); chk("lz_d2", 32'(bus0.seg_out), 32'h00);
                    chk("lz_d2_an", 32'(bus0.an_n), 32'hB);
                    chk("lz_d2_nolz", 32'(bus1.seg_out), 32'h3F);
        adv_to(92); chk("lz_d3", 32'(bus0.seg_out), 32'h00);
                    chk("lz_d3_an", 32'(bus0.an_n), 32'h7);
                    chk("lz_d3_nolz", 32'(bus1.seg_out), 32'h3F);

        // Invalid digit and decimal point
        adv_to(94); bus0.load = 1'b1; bus0.bcd_in = 16'hA005; bus0.dp_in = 4'b1000;
        adv_to(95); chk("inv_ack", 32'(bus0.load_ack), 32'h1);
                    bus0.load = 1'b0; bus0.dp_in = 4'b0000;
        adv_to(98); chk("inv_d0", 32'(bus0.seg_out), 32'h6D);
                    chk("inv_d0_dp", 32'(bus0.dp_out), 32'h0);
                    chk("inv_d0_nolz", 32'(bus1.seg_out), 32'h6D);
        adv_to(104); chk("inv_d1", 32'(bus0.seg_out), 32'h00);
                     chk("inv_d1_nolz", 32'(bus1.seg_out), 32'h3F);
        adv_to(110); chk("inv_d2", 32'(bus0.seg_out), 32'h00);
                     chk("inv_d2_an", 32'(bus0.an_n), 32'hB);
        adv_to(116); chk("inv_d3", 32'(bus0.seg_out), 32'h00);
                     chk("inv_d3_dp", 32'(bus0.dp_out), 32'h1);
                     chk("inv_d3_an", 32'(bus0.an_n), 32'h7);
                     chk("inv_d3_nolz", 32'(bus1.seg_out), 32'h00);
                     chk("inv_d3_dp_nolz", 32'(bus1.dp_out), 32'h1);

        // Back-to-back loads: last value wins, one ack each
        adv_to(122); bus0.load = 1'b1; bus0.bcd_in = 16'h1111;
        adv_to(123); chk("b2b_ack1", 32'(bus0.load_ack), 32'h1);
                     bus0.bcd_in = 16'h2222;
        adv_to(124); chk("b2b_ack2", 32'(bus0.load_ack), 32'h1);
                     bus0.load = 1'b0;
        adv_to(125); chk("b2b_ack_clr", 32'(bus0.load_ack), 32'h0);
        adv_to(146); chk("b2b_d0", 32'(bus0.seg_out), 32'h5B);
        adv_to(164); chk("b2b_d3", 32'(bus0.seg_out), 32'h5B);
                     chk("b2b_d3_an", 32'(bus0.an_n), 32'h7);

        // Load on the frame_done edge goes straight to display
        adv_to(167); bus0.load = 1'b1; bus0.bcd_in = 16'h3333;
        adv_to(168); chk("fdl_fd", 32'(bus0.frame_done), 32'h1);
                     chk("fdl_ack", 32'(bus0.load_ack), 32'h1);
                     bus0.load = 1'b0;
        adv_to(170); chk("fdl_d0", 32'(bus0.seg_out), 32'h4F);
                     chk("fdl_d0_nolz", 32'(bus1.seg_out), 32'h4F);

        // Enable drop during digit 2 ON
        adv_to(183); chk("en_pre_an", 32'(bus0.an_n), 32'hB);
                     chk("en_pre_idx", 32'(bus0.digit_idx), 32'h2);
                     bus0.en = 1'b0;
        adv_to(184); chk("en_off_an", 32'(bus0.an_n), 32'hF);
                     chk("en_off_idx", 32'(bus0.digit_idx), 32'h0);
                     chk("en_off_seg", 32'(bus0.seg_out), 32'h00);
        adv_to(185); bus0.load = 1'b1; bus0.bcd_in = 16'h5555;
        adv_to(186); chk("en_off_ack", 32'(bus0.load_ack), 32'h1);
                     bus0.load = 1'b0;
        adv_to(187); chk("en_off_hold", 32'(bus0.an_n), 32'hF);
                     bus0.en = 1'b1;
        adv_to(188); chk("en_on_blank", 32'(bus0.an_n), 32'hF);
        adv_to(189); chk("en_on_d0_an", 32'(bus0.an_n), 32'hE);
                     chk("en_on_d0_seg", 32'(bus0.seg_out), 32'h4F);

        // Asynchronous reset mid-ON
        adv_to(190);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(bus0.an_n), 32'hF);
        chk("arst_seg", 32'(bus0.seg_out), 32'h00);
        chk("arst_idx", 32'(bus0.digit_idx), 32'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        // Display cleared and pending load discarded by reset
        adv_to(2);  chk("post_d0", 32'(bus0.seg_out), 32'h3F);
        adv_to(24); chk("post_fd", 32'(bus0.frame_done), 32'h1);
        adv_to(26); chk("post_pend_d0", 32'(bus0.seg_out), 32'h3F);
        adv_to(32); chk("post_pend_d1_nolz", 32'(bus1.seg_out), 32'h3F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode seven-segment display.
- Shares a single BCD-to-segment decoder across DIGITS digit positions.
- Sequences digit anodes with an inter-digit blanking gap to suppress ghosting.
- Accepts new display values through a load handshake and applies them only at frame boundaries, so a frame never shows torn data.
- Sits between the system-side value registers and the board pins.

Parameters:
DIGITS, 4, number of digit positions; minimum 2.
PRESCALE, 50000, clk cycles a digit is lit (ON phase); minimum 1.
BLANK_CYC, 16, clk cycles all anodes are off between digits (BLANK phase); minimum 1.
LZ_SUPPRESS, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  scan enable.
load  in  1  single-cycle strobe; capture bcd_in/dp_in.
bcd_in  in  4*DIGITS  packed BCD digits; digit 0 = bits [3:0] = least significant.
dp_in  in  DIGITS  decimal point per digit.
load_ack  out  1  one-cycle pulse, cycle after load.
seg_out  out  7  segments, active-high; bit0=a … bit6=g.
dp_out  out  1  decimal point, active-high.
an_n  out  DIGITS  digit anodes, active-low.
digit_idx  out  clog2(DIGITS)  digit currently in ON or BLANK phase.
frame_done  out  1  one-cycle pulse at end of last digit's ON phase.

Behaviour:
- Reset (async assert, sync release) sets:
  - staging regs, display regs, pending = 0; phase counter = 0; digit_idx = 0; state = BLANK.
  - an_n = all 1; seg_out = 0; dp_out = 0; load_ack = 0; frame_done = 0.
- All outputs are registered. They change on the same edge the FSM enters a phase; no combinational path from inputs to pins.
- FSM has two states:
  - BLANK: an_n all 1, seg_out 0, dp_out 0. After BLANK_CYC cycles, go to ON.
  - ON: an_n[digit_idx] = 0, others 1. seg_out = decode(display[digit_idx]); dp_out = display_dp[digit_idx]. After PRESCALE cycles, go to BLANK and set digit_idx = (digit_idx+1) mod DIGITS.
- Timing: slot = BLANK_CYC+PRESCALE cycles; frame = DIGITS slots. The phase counter width covers max(PRESCALE, BLANK_CYC).
- frame_done pulses on the ON→BLANK edge when digit_idx = DIGITS-1.
- Load handshake:
  - load=1 captures bcd_in/dp_in into staging and sets pending=1; load_ack pulses the next cycle.
  - A load while pending overwrites staging; last value wins, one ack per load.
  - On the frame_done edge with pending=1, staging is copied to display and pending cleared.
  - If load coincides with the frame_done edge, bcd_in/dp_in go straight to display and pending ends at 0.
- Digit blanking:
  - A digit value > 9 gives seg_out = 0 for that slot. The anode is still driven; dp is unaffected.
  - With LZ_SUPPRESS=1, the contiguous run of zero digits from DIGITS-1 downward is blanked (seg_out=0). Digit 0 is never suppressed. dp is still shown.
- en=0: on the next edge, go to BLANK with counter=0, digit_idx=0, outputs blank, frame_done=0. Loads and acks still operate, but pending data is not applied while disabled. On en rising, the scan starts with BLANK of digit 0.
- Async reset mid-frame aborts immediately; pending data is discarded.

Decomposition:
- Package seg_scan_pkg holds:
  - state enum {BLANK, ON};
  - 7-bit segment constants SEG_BLANK=7'h00 and SEG_DIGIT[0..9] = 3F,06,5B,4F,66,6D,7D,07,7F,6F;
  - a clog2 width helper.
- One natural sub-module: the combinational decoder, instantiated once. This is the existing sevenSegment decoder (bcd[3:0] → seg[6:0]), whose output must match SEG_DIGIT. The controller applies the >9 and leading-zero masking around it.

Test Plan:
(Benches use DIGITS=4, PRESCALE=4, BLANK_CYC=2.)
1. Reset/start: hold rst_n=0 → an_n=4'hF, seg_out=0. Release with en=1, display 0 → 2 cycles an_n=F, then 4 cycles an_n=4'b1110 with seg_out=7'h3F, then digit_idx=1. frame_done first pulses at cycle 24.
2. Load timing: load 16'h1234 mid-frame → load_ack the next cycle; old data persists until frame_done. The next frame shows digit0 seg_out=7'h66 ('4') through digit3 seg_out=7'h06 ('1').
3. Leading zeros: load 16'h0070 with LZ_SUPPRESS=1 → digits 3 and 2 show seg_out=0 with an_n asserted; digit1=7'h07; digit0=7'h3F. The same data with LZ_SUPPRESS=0 shows 3F,3F,07,3F.
4. Invalid digits and dp: load 16'hA005, dp_in=4'b1000 → digit3 seg_out=0, dp_out=1. Digits 2 and 1 are suppressed. digit0=7'h6D.
5. Enable drop and reset: drop en during digit2 ON → next cycle an_n=F, digit_idx=0; on re-enable, 2 blank cycles, then digit0. Assert rst_n mid-ON → an_n=F immediately, without waiting for a clock edge.
6. Load collisions: load 16'h1111 then 16'h2222 on consecutive cycles → two acks; 16'h2222 is displayed. A load on the frame_done cycle is visible on the very next digit0 ON phase, and pending=0 afterwards.
